// File: rtl/pulse_burst_pkg.sv
// ============================================================================
// Module   : pulse_burst_pkg
// Purpose  : Shared types and default parameter values for the pulse burst
//            generator (FSM state encoding, default channel/field widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_burst_pkg;

  // Default configuration of the generator.
  localparam int unsigned C_CH_NUM_DEF = 2;  // output channels (1..16)
  localparam int unsigned C_CNT_W_DEF  = 7;  // width/gap field width
  localparam int unsigned C_NUM_W_DEF  = 4;  // pulse-count field width

  // Burst FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // outputs low, waiting for a trigger edge
    ST_HIGH = 2'd1,  // enabled channels driven high
    ST_LOW  = 2'd2   // gap between two pulses of a burst
  } state_t;

endpackage : pulse_burst_pkg

`default_nettype wire

// File: rtl/pulse_burst_gen_trig_edge_det.sv
// ============================================================================
// Module   : trig_edge_det
// Purpose  : Two-register input stage and rising-edge detector for the burst
//            trigger. The rise output is derived from registers only, so no
//            combinational path exists from the trigger pin.
// Ports    : sys_clk   in  block clock
//            sys_rst_n in  asynchronous active-low reset
//            trig_i    in  trigger level
//            rise_o    out one-cycle high on a sampled rising edge
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic trig_i,
  output logic rise_o
);

  logic trig_d1_q;
  logic trig_d2_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      trig_d1_q <= 1'b0;
      trig_d2_q <= 1'b0;
    end else begin
      trig_d1_q <= trig_i;
      trig_d2_q <= trig_d1_q;
    end
  end

  // High in the cycle after trig is first sampled high.
  assign rise_o = trig_d1_q & ~trig_d2_q;

endmodule : trig_edge_det

`default_nettype wire

// File: rtl/pulse_burst_gen.sv
// ============================================================================
// Module   : pulse_burst_gen
// Purpose  : Multi-channel burst generator. A rising trigger edge latches
//            width/gap/count/mask and emits <num> identical pulses of <width>
//            clocks separated by max(gap,1) clocks on the masked channels.
// Ports    : sys_clk    in  block clock
//            sys_rst_n  in  asynchronous active-low reset
//            trig       in  burst request level (rising edge acts)
//            cfg_width  in  [CNT_W]  high time per pulse, clocks
//            cfg_gap    in  [CNT_W]  low time between pulses, clocks
//            cfg_num    in  [NUM_W]  pulses per burst
//            cfg_ch_en  in  [CH_NUM] channel enable mask
//            pulse_out  out [CH_NUM] registered burst outputs
//            busy       out burst in progress
//            done       out one-cycle strobe at burst end / rejected trigger
// Build    : PULSE_BURST_RETRIG_EN - when defined, a trigger edge during a
//            burst restarts it with the newly latched configuration; when
//            undefined such an edge is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_burst_gen
  import pulse_burst_pkg::*;
#(
  parameter int unsigned CH_NUM = C_CH_NUM_DEF,
  parameter int unsigned CNT_W  = C_CNT_W_DEF,
  parameter int unsigned NUM_W  = C_NUM_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              trig,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_gap,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic [CH_NUM-1:0] cfg_ch_en,
  output logic [CH_NUM-1:0] pulse_out,
  output logic              busy,
  output logic              done
);

  // --------------------------------------------------------------------------
  // Trigger edge detection
  // --------------------------------------------------------------------------
  logic trig_rise;

  trig_edge_det u_trig_edge_det (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .trig_i    (trig),
    .rise_o    (trig_rise)
  );

  // --------------------------------------------------------------------------
  // State, counters, shadow configuration and output registers
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [NUM_W-1:0]  pcnt_q,  pcnt_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic [CNT_W-1:0]  gap_q,   gap_d;
  logic [NUM_W-1:0]  num_q,   num_d;
  logic [CH_NUM-1:0] mask_q,  mask_d;
  logic [CH_NUM-1:0] pulse_q, pulse_d;
  logic              done_q,  done_d;

  // Terminal counts. A zero gap behaves as a one-clock gap so that
  // consecutive pulses always show a low cycle between them.
  logic [CNT_W-1:0] width_last;
  logic [CNT_W-1:0] gap_last;

  assign width_last = width_q - CNT_W'(1);
  assign gap_last   = (gap_q == '0) ? '0 : (gap_q - CNT_W'(1));

  // A trigger edge that (re)starts a burst.
  logic accept;

`ifdef PULSE_BURST_RETRIG_EN
  assign accept = trig_rise;
`else
  // Edges while busy are dropped; a new edge needs trig to go low first.
  assign accept = trig_rise && (state_q == ST_IDLE);
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    width_d = width_q;
    gap_d   = gap_q;
    num_d   = num_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    pulse_d = '0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end

      ST_HIGH: begin
        if (cnt_q == width_last) begin
          cnt_d = '0;
          if (pcnt_q == num_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_LOW: begin
        if (cnt_q == gap_last) begin
          cnt_d   = '0;
          pcnt_d  = pcnt_q + NUM_W'(1);
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Accepted edge overrides the normal progression. When it lands on the
    // last cycle of a burst being restarted, the end-of-burst strobe is
    // suppressed. A zero count or width is rejected with a done strobe; in a
    // retrigger build that also abandons the running burst.
    if (accept) begin
      width_d = cfg_width;
      gap_d   = cfg_gap;
      num_d   = cfg_num;
      mask_d  = cfg_ch_en;
      cnt_d   = '0;
      done_d  = 1'b0;
      if ((cfg_num == '0) || (cfg_width == '0)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_HIGH;
        pcnt_d  = NUM_W'(1);
      end
    end

    // Output register is loaded from the next state so the pulse appears on
    // the same edge that enters HIGH.
    pulse_d = (state_d == ST_HIGH) ? mask_d : '0;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      width_q <= '0;
      gap_q   <= '0;
      num_q   <= '0;
      mask_q  <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule : pulse_burst_gen

`default_nettype wire
